reg_file_sb: RTL and testbench

//  Parametrised 2-read/2-write register file with a per-register busy scoreboard.

---
 rtl/reg_file_sb.sv | 126 ++++++++++++
 tb/tb_reg_file_sb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// 2-read/2-write register file with a per-register busy scoreboard; state updates on negedge clk.
// Optional macro REG_FILE_BYPASS_EN forwards same-edge write data and busy-clear to the read ports.
module reg_file_sb #(
  parameter int REG_WIDTH   = 32,
  parameter int REG_COUNT   = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index_1,
  input  logic [INDEX_WIDTH-1:0] rd_index_2,
  output logic [REG_WIDTH-1:0]   rd_data_1,
  output logic [REG_WIDTH-1:0]   rd_data_2,
  output logic                   rd_busy_1,
  output logic                   rd_busy_2,
  input  logic                   wr_en_0,
  input  logic [INDEX_WIDTH-1:0] wr_index_0,
  input  logic [REG_WIDTH-1:0]   wr_data_0,
  input  logic                   wr_en_1,
  input  logic [INDEX_WIDTH-1:0] wr_index_1,
  input  logic [REG_WIDTH-1:0]   wr_data_1,
  input  logic                   rsv_en,
  input  logic [INDEX_WIDTH-1:0] rsv_index,
  output logic [CNT_WIDTH-1:0]   busy_count
);

  localparam logic [INDEX_WIDTH:0] REG_LIMIT = (INDEX_WIDTH+1)'(REG_COUNT);

  // Register 0 has no storage at all: it reads as zero and can never be busy.
  logic [REG_WIDTH-1:0] regs_r [1:REG_COUNT-1];
  logic [REG_COUNT-1:1] busy_r;
  logic [REG_COUNT-1:1] busy_nxt_s;
  logic [CNT_WIDTH-1:0] busy_count_r;
  logic [CNT_WIDTH-1:0] rise_cnt_s;
  logic [CNT_WIDTH-1:0] fall_cnt_s;
  logic                 wr_ok_0_s;
  logic                 wr_ok_1_s;
  logic                 rsv_ok_s;

  function automatic logic idx_valid(input logic [INDEX_WIDTH-1:0] idx);
    return (idx != {INDEX_WIDTH{1'b0}}) && ({1'b0, idx} < REG_LIMIT);
  endfunction

  function automatic logic [REG_WIDTH-1:0] lookup_data(input logic [INDEX_WIDTH-1:0] idx);
    logic [REG_WIDTH-1:0] data;
    data = {REG_WIDTH{1'b0}};
    for (int i = 1; i < REG_COUNT; i++) begin
      data = (idx == INDEX_WIDTH'(i)) ? regs_r[i] : data;
    end
    return data;
  endfunction

  function automatic logic lookup_busy(input logic [INDEX_WIDTH-1:0] idx);
    logic busy;
    busy = 1'b0;
    for (int i = 1; i < REG_COUNT; i++) begin
      busy = (idx == INDEX_WIDTH'(i)) ? busy_r[i] : busy;
    end
    return busy;
  endfunction

  // Returns {busy, data} for one read port.
  function automatic logic [REG_WIDTH:0] read_port(input logic [INDEX_WIDTH-1:0] idx);
    logic [REG_WIDTH:0] result;
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok_1_s && (wr_index_1 == idx)) begin
      result = {rsv_ok_s && (rsv_index == idx), wr_data_1};
    end else if (wr_ok_0_s && (wr_index_0 == idx)) begin
      result = {rsv_ok_s && (rsv_index == idx), wr_data_0};
    end else begin
      result = {lookup_busy(idx), lookup_data(idx)};
    end
`else
    result = {lookup_busy(idx), lookup_data(idx)};
`endif
    return result;
  endfunction

  assign wr_ok_0_s = wr_en_0 && idx_valid(wr_index_0);
  assign wr_ok_1_s = wr_en_1 && idx_valid(wr_index_1);
  assign rsv_ok_s  = rsv_en && idx_valid(rsv_index);

  assign {rd_busy_1, rd_data_1} = read_port(rd_index_1);
  assign {rd_busy_2, rd_data_2} = read_port(rd_index_2);
  assign busy_count             = busy_count_r;

  // Next busy vector plus the number of 0->1 and 1->0 transitions it implies.
  always_comb begin
    busy_nxt_s = busy_r;
    rise_cnt_s = {CNT_WIDTH{1'b0}};
    fall_cnt_s = {CNT_WIDTH{1'b0}};
    for (int i = 1; i < REG_COUNT; i++) begin
      // A same-edge reserve beats the write-back: the new producer owns the register.
      busy_nxt_s[i] = (rsv_ok_s && (rsv_index == INDEX_WIDTH'(i))) ? 1'b1 :
                      ((wr_ok_0_s && (wr_index_0 == INDEX_WIDTH'(i))) ||
                       (wr_ok_1_s && (wr_index_1 == INDEX_WIDTH'(i)))) ? 1'b0 : busy_r[i];
      rise_cnt_s = rise_cnt_s + CNT_WIDTH'(busy_nxt_s[i] & ~busy_r[i]);
      fall_cnt_s = fall_cnt_s + CNT_WIDTH'(~busy_nxt_s[i] & busy_r[i]);
    end
  end

  // Register storage, busy bits and the incremental busy counter.
  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_r[i] <= {REG_WIDTH{1'b0}};
      end
      busy_r       <= {(REG_COUNT-1){1'b0}};
      busy_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (wr_ok_1_s && (wr_index_1 == INDEX_WIDTH'(i))) begin
          regs_r[i] <= wr_data_1;
        end else if (wr_ok_0_s && (wr_index_0 == INDEX_WIDTH'(i))) begin
          regs_r[i] <= wr_data_0;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      busy_r       <= busy_nxt_s;
      busy_count_r <= busy_count_r + rise_cnt_s - fall_cnt_s;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model (honours REG_FILE_BYPASS_EN).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_index_1, rd_index_2, wr_index_0, wr_index_1, rsv_index;
  logic [31:0] rd_data_1, rd_data_2, wr_data_0, wr_data_1;
  logic        rd_busy_1, rd_busy_2, wr_en_0, wr_en_1, rsv_en;
  logic [5:0]  busy_count;

  int checks   = 0;
  int failures = 0;

  bit [31:0] m_reg  [32];
  bit        m_busy [32];

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .rd_index_1(rd_index_1), .rd_index_2(rd_index_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .wr_en_0(wr_en_0), .wr_index_0(wr_index_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_index_1(wr_index_1), .wr_data_1(wr_data_1),
    .rsv_en(rsv_en), .rsv_index(rsv_index),
    .busy_count(busy_count)
  );

  // Reference model: plain arrays updated from the current inputs at the active edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en_0 && wr_index_0 != 5'd0) begin
        m_reg[wr_index_0]  = wr_data_0;
        m_busy[wr_index_0] = 1'b0;
      end
      if (wr_en_1 && wr_index_1 != 5'd0) begin
        m_reg[wr_index_1]  = wr_data_1;
        m_busy[wr_index_1] = 1'b0;
      end
      if (rsv_en && rsv_index != 5'd0) m_busy[rsv_index] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] idx);
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_1 && wr_index_1 != 5'd0 && wr_index_1 == idx) return wr_data_1;
    if (wr_en_0 && wr_index_0 != 5'd0 && wr_index_0 == idx) return wr_data_0;
`endif
    return m_reg[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
`ifdef REG_FILE_BYPASS_EN
    if ((wr_en_1 && wr_index_1 != 5'd0 && wr_index_1 == idx) ||
        (wr_en_0 && wr_index_0 != 5'd0 && wr_index_0 == idx))
      return rsv_en && rsv_index == idx;
`endif
    return m_busy[idx];
  endfunction

  function automatic logic [5:0] exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  function automatic logic [4:0] pick_idx();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    rst = 1'b0;
    wr_en_0 = 1'b0; wr_index_0 = 5'd0; wr_data_0 = 32'h0;
    wr_en_1 = 1'b0; wr_index_1 = 5'd0; wr_data_1 = 32'h0;
    rsv_en = 1'b0; rsv_index = 5'd0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (20) begin
      wr_en_0 = 1'b1; wr_index_0 = 5'($urandom_range(1, 31)); wr_data_0 = $urandom;
      rsv_en = 1'b1; rsv_index = 5'($urandom_range(1, 31));
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_count !== 6'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", busy_count);
    end
    for (int i = 0; i < 32; i++) begin
      rd_index_1 = 5'(i); rd_index_2 = 5'(31 - i);
      #1;
      checks += 2;
      if (rd_data_1 !== 32'h0 || rd_busy_1 !== 1'b0) begin
        failures++; $display("FAIL reset_port1[%0d]: got %h/%b expected 0/0", i, rd_data_1, rd_busy_1);
      end
      if (rd_data_2 !== 32'h0 || rd_busy_2 !== 1'b0) begin
        failures++; $display("FAIL reset_port2[%0d]: got %h/%b expected 0/0", 31 - i, rd_data_2, rd_busy_2);
      end
      sync();
    end
  endtask

  task automatic test_write_read();
    wr_en_0 = 1'b1; wr_index_0 = 5'd5; wr_data_0 = 32'hDEADBEEF;
    tick();
    idle();
    rd_index_1 = 5'd5;
    #1;
    checks++;
    if (rd_data_1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_read: got %h expected deadbeef", rd_data_1);
    end
    wr_en_0 = 1'b1; wr_index_0 = 5'd0; wr_data_0 = 32'h1234;
    tick();
    idle();
    rd_index_2 = 5'd0;
    #1;
    checks++;
    if (rd_data_2 !== 32'h0 || rd_busy_2 !== 1'b0) begin
      failures++; $display("FAIL reg0_write: got %h/%b expected 0/0", rd_data_2, rd_busy_2);
    end
  endtask

  task automatic test_same_index();
    wr_en_0 = 1'b1; wr_index_0 = 5'd7; wr_data_0 = 32'h11;
    wr_en_1 = 1'b1; wr_index_1 = 5'd7; wr_data_1 = 32'h22;
    tick();
    idle();
    rd_index_1 = 5'd7;
    #1;
    checks++;
    if (rd_data_1 !== 32'h22) begin
      failures++; $display("FAIL same_index: got %h expected 22", rd_data_1);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_index = 5'd3;
    tick();
    rsv_index = 5'd9;
    tick();
    idle();
    rd_index_1 = 5'd3; rd_index_2 = 5'd9;
    #1;
    checks += 2;
    if (rd_busy_1 !== 1'b1 || rd_busy_2 !== 1'b1) begin
      failures++; $display("FAIL reserve_busy: got %b/%b expected 1/1", rd_busy_1, rd_busy_2);
    end
    if (busy_count !== 6'd2) begin
      failures++; $display("FAIL reserve_count: got %0d expected 2", busy_count);
    end
    wr_en_0 = 1'b1; wr_index_0 = 5'd3; wr_data_0 = $urandom;
    rsv_en = 1'b1; rsv_index = 5'd3;
    tick();
    idle();
    #1;
    checks += 2;
    if (rd_busy_1 !== 1'b1) begin
      failures++; $display("FAIL rsv_wins_busy: got %b expected 1", rd_busy_1);
    end
    if (busy_count !== 6'd2) begin
      failures++; $display("FAIL rsv_wins_count: got %0d expected 2", busy_count);
    end
    wr_en_0 = 1'b1; wr_index_0 = 5'd3; wr_data_0 = $urandom;
    wr_en_1 = 1'b1; wr_index_1 = 5'd9; wr_data_1 = $urandom;
    tick();
    idle();
    #1;
    checks += 2;
    if (rd_busy_1 !== 1'b0 || rd_busy_2 !== 1'b0) begin
      failures++; $display("FAIL release_busy: got %b/%b expected 0/0", rd_busy_1, rd_busy_2);
    end
    if (busy_count !== 6'd0) begin
      failures++; $display("FAIL release_count: got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_reset_override();
    rsv_en = 1'b1; rsv_index = 5'd4;
    tick();
    idle();
    rst = 1'b1;
    wr_en_0 = 1'b1; wr_index_0 = 5'd4; wr_data_0 = 32'hFF;
    tick();
    idle();
    rd_index_1 = 5'd4;
    #1;
    checks += 2;
    if (rd_data_1 !== 32'h0 || rd_busy_1 !== 1'b0) begin
      failures++; $display("FAIL rst_override: got %h/%b expected 0/0", rd_data_1, rd_busy_1);
    end
    if (busy_count !== 6'd0) begin
      failures++; $display("FAIL rst_override_count: got %0d expected 0", busy_count);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want_data;
    logic        want_busy;
    wr_en_0 = 1'b1; wr_index_0 = 5'd6; wr_data_0 = 32'h55;
    tick();
    idle();
    rsv_en = 1'b1; rsv_index = 5'd6;
    tick();
    idle();
    wr_en_1 = 1'b1; wr_index_1 = 5'd6; wr_data_1 = 32'hCAFE0001;
    rd_index_1 = 5'd6;
    #1;
`ifdef REG_FILE_BYPASS_EN
    want_data = 32'hCAFE0001; want_busy = 1'b0;
`else
    want_data = 32'h55; want_busy = 1'b1;
`endif
    checks++;
    if (rd_data_1 !== want_data || rd_busy_1 !== want_busy) begin
      failures++; $display("FAIL bypass_pre_edge: got %h/%b expected %h/%b", rd_data_1, rd_busy_1, want_data, want_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data_1 !== 32'hCAFE0001 || rd_busy_1 !== 1'b0) begin
      failures++; $display("FAIL bypass_post_edge: got %h/%b expected cafe0001/0", rd_data_1, rd_busy_1);
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      rst        = ($urandom_range(0, 63) == 0);
      wr_en_0    = 1'($urandom_range(0, 1)); wr_index_0 = pick_idx(); wr_data_0 = $urandom;
      wr_en_1    = 1'($urandom_range(0, 1)); wr_index_1 = pick_idx(); wr_data_1 = $urandom;
      rsv_en     = 1'($urandom_range(0, 1)); rsv_index  = pick_idx();
      rd_index_1 = pick_idx(); rd_index_2 = pick_idx();
      #1;
      checks += 3;
      if (rd_data_1 !== exp_data(rd_index_1) || rd_busy_1 !== exp_busy(rd_index_1)) begin
        failures++; $display("FAIL rand_port1[%0d]: got %h/%b expected %h/%b", rd_index_1,
                             rd_data_1, rd_busy_1, exp_data(rd_index_1), exp_busy(rd_index_1));
      end
      if (rd_data_2 !== exp_data(rd_index_2) || rd_busy_2 !== exp_busy(rd_index_2)) begin
        failures++; $display("FAIL rand_port2[%0d]: got %h/%b expected %h/%b", rd_index_2,
                             rd_data_2, rd_busy_2, exp_data(rd_index_2), exp_busy(rd_index_2));
      end
      if (busy_count !== exp_count()) begin
        failures++; $display("FAIL rand_count: got %0d expected %0d", busy_count, exp_count());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rd_index_1 = 5'd0; rd_index_2 = 5'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_same_index();
    test_scoreboard();
    test_reset_override();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
